// File: rtl/pipe_pkg.sv
// Shared types for the decode-stage hazard/forwarding controller.
//   stage_info_t : per-stage shadow of {valid, rd, reg_write, mem_read}
//   FWD_*        : ALU operand MUX2x4 select encoding (3 is never driven)
package pipe_pkg;

    localparam int unsigned RF_AW = 5;
    localparam int unsigned SEL_W = 2;

    typedef logic [SEL_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'd0;
    localparam fwd_sel_t FWD_EXMEM = 2'd1;
    localparam fwd_sel_t FWD_MEMWB = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] rd;
        logic             reg_write;
        logic             mem_read;
    } stage_info_t;

    localparam stage_info_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/fwd_match.sv
// Combinational forwarding source selection for one ALU operand.
//   rs     : source register index of the decode instruction
//   use_rs : decode instruction actually reads rs
//   ex_q   : shadow of the instruction currently in EX
//   mem_q  : shadow of the instruction currently in MEM
//   sel_c  : FWD_RF / FWD_EXMEM / FWD_MEMWB
module fwd_match
    import pipe_pkg::*;
(
    input  logic [RF_AW-1:0] rs,
    input  logic             use_rs,
    input  stage_info_t      ex_q,
    input  stage_info_t      mem_q,
    output fwd_sel_t         sel_c
);

    // A load in EX has no data yet; that case is covered by the stall, and the
    // re-evaluated instruction then picks the load up from MEM/WB.
    always_comb begin
        sel_c = FWD_RF;
        if (use_rs && (rs != '0)) begin
            if (ex_q.valid && ex_q.reg_write && !ex_q.mem_read && (ex_q.rd == rs)) begin
                sel_c = FWD_EXMEM;
            end else if (mem_q.valid && mem_q.reg_write && (mem_q.rd == rs)) begin
                sel_c = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Decode-stage hazard/forwarding controller for the 5-stage RV32I pipeline.
//   clk, rst_n       : clock, synchronous active-low reset
//   id_*             : decode-stage instruction fields
//   flush            : branch/jump redirect, kills the decode instruction
//   stall            : hold PC and IF/ID on load-use (combinational)
//   ex_bubble        : ID/EX loads a NOP this edge (combinational)
//   fwd_a_sel/_b_sel : registered operand MUX selects, valid while instr is in EX
//   stall_cnt        : saturating count of stall cycles
module hazard_forward_unit
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    stage_info_t      ex_q, mem_q, wb_q;
    stage_info_t      ex_d, mem_d, wb_d;
    fwd_sel_t         fwd_a_sel_q, fwd_a_sel_d;
    fwd_sel_t         fwd_b_sel_q, fwd_b_sel_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [RF_AW-1:0] rs1_c, rs2_c, rd_c;
    fwd_sel_t         fwd_a_c, fwd_b_c;
    logic             rs1_hit_c, rs2_hit_c;
    logic             stall_c, bubble_c;
    logic             unused_wb_c;

    assign rs1_c = RF_AW'(id_rs1);
    assign rs2_c = RF_AW'(id_rs2);
    assign rd_c  = RF_AW'(id_rd);

    fwd_match u_fwd_a (
        .rs     (rs1_c),
        .use_rs (id_use_rs1),
        .ex_q   (ex_q),
        .mem_q  (mem_q),
        .sel_c  (fwd_a_c)
    );

    fwd_match u_fwd_b (
        .rs     (rs2_c),
        .use_rs (id_use_rs2),
        .ex_q   (ex_q),
        .mem_q  (mem_q),
        .sel_c  (fwd_b_c)
    );

    // Load-use detection, bubble insertion and next-state for all registers.
    always_comb begin
        rs1_hit_c   = 1'b0;
        rs2_hit_c   = 1'b0;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        ex_d        = STAGE_BUBBLE;
        mem_d       = ex_q;
        wb_d        = mem_q;
        fwd_a_sel_d = FWD_RF;
        fwd_b_sel_d = FWD_RF;
        stall_cnt_d = stall_cnt_q;

        rs1_hit_c = id_use_rs1 && (rs1_c == ex_q.rd);
        rs2_hit_c = id_use_rs2 && (rs2_c == ex_q.rd);

        // flush kills the decode instruction, so it can never cause a stall
        stall_c  = id_valid && !flush && ex_q.valid && ex_q.mem_read &&
                   (ex_q.rd != '0) && (rs1_hit_c || rs2_hit_c);
        bubble_c = stall_c || flush || !id_valid;

        if (!bubble_c) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = rd_c;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            fwd_a_sel_d    = fwd_a_c;
            fwd_b_sel_d    = fwd_b_c;
        end

        if (stall_c && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q        <= STAGE_BUBBLE;
            mem_q       <= STAGE_BUBBLE;
            wb_q        <= STAGE_BUBBLE;
            fwd_a_sel_q <= FWD_RF;
            fwd_b_sel_q <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            fwd_a_sel_q <= fwd_a_sel_d;
            fwd_b_sel_q <= fwd_b_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Regfile is write-before-read, so WB is kept for debug visibility only.
    assign unused_wb_c = ^wb_q;

    assign stall     = stall_c;
    assign ex_bubble = bubble_c;
    assign fwd_a_sel = fwd_a_sel_q;
    assign fwd_b_sel = fwd_b_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule
